ascon_core_arbiter: RTL and testbench
=====================================

Name: ascon_core_arbiter

Overview:
Shares one ascon_core instance between NREQ independent requesters (e.g. a host-register channel and a DMA channel). Arbitration is round-robin at transaction granularity. A grant is held from key/data injection until the core's done pulse, so one AEAD/hash operation is never interleaved with another. The block sits directly in front of ascon_core and muxes all key/bdi/bdo/auth/done traffic between the granted requester and the core.

Parameters:
NREQ, 2, number of requester channels (2..8)
CCW, from config.sv (32), core data/key width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
req  in  NREQ  per-requester transaction request; must be held until that requester's done
gnt  out  NREQ  one-hot grant, registered
r_key  in  NREQ x CCW  per-requester key word
r_key_valid  in  NREQ  key valid
r_key_ready  out  NREQ  key ready
r_bdi  in  NREQ x CCW  block data in
r_bdi_valid  in  NREQ x CCW/8  byte valids
r_bdi_ready  out  NREQ  bdi ready
r_bdi_type  in  NREQ x 4  bdi type
r_bdi_eot, r_bdi_eoi  in  NREQ each  end of type / end of input
r_mode  in  NREQ x 4  requested mode; sampled at grant
r_bdo  out  NREQ x CCW  block data out
r_bdo_valid  out  NREQ  bdo valid
r_bdo_ready  in  NREQ  bdo ready
r_bdo_type  out  NREQ x 4  bdo type
r_bdo_eot  out  NREQ  bdo end of type
r_bdo_eoo  in  NREQ  end of output
r_auth, r_auth_valid  out  NREQ each  tag-check result
r_done  out  NREQ  operation complete
c_*  mirror of the ascon_core port list (key, key_valid, key_ready, bdi, bdi_valid, bdi_ready, bdi_type, bdi_eot, bdi_eoi, mode, bdo, bdo_valid, bdo_ready, bdo_type, bdo_eot, bdo_eoo, auth, auth_valid, done) with direction inverted
busy  out  1  a grant is active

Behaviour:
- Reset (rst=0, async): state=IDLE, gnt=0, busy=0, rr pointer=0, latched mode=0. All r_* outputs and all c_* valid/ready/mode outputs are 0.
- FSM has two states: IDLE and BUSY.
- IDLE, no req: stay in IDLE. All c_ valids are 0, c_bdo_ready=0, c_mode=0.
- IDLE, any req: pick the first set req starting at the pointer index, wrapping modulo NREQ. At the next edge: gnt[i]=1, busy=1, mode_q=r_mode[i], state=BUSY. Grant latency from req is 1 cycle.
- BUSY, core-bound signals: c_key, c_key_valid, c_bdi*, c_bdo_ready and c_bdo_eoo are driven combinationally from requester i. c_mode is driven from mode_q.
- BUSY, requester-bound signals: r_*[i] is driven from the core. For every j≠i, all ready/valid/auth/done outputs are 0 and data outputs are 0.
- No handshake is ever presented to a non-granted requester, so its valids stall with no side effects.
- BUSY, c_done=1: r_done[i] pulses in the same cycle. At the edge: state=IDLE, gnt=0, busy=0, pointer=(i+1) mod NREQ.
- There is always exactly one IDLE bubble cycle between grants.
- If req[i] drops during BUSY, it is ignored. The grant holds until c_done because the core cannot be aborted.
- If c_done occurs in IDLE (spurious), it is ignored and no r_done is driven.
- A requester that keeps req high after its done is served again only after every other pending requester has been served once (round-robin fairness).
- Asserting rst mid-BUSY aborts immediately to the reset state. The core shares the same reset.
- Mode changes on r_mode during BUSY have no effect.

Decomposition:
- Shared definitions go in config.sv: arb_state_t enum (IDLE, BUSY) and the NREQ default constant.
- Sub-module rr_pick is natural. It is purely combinational: inputs req[NREQ] and ptr; outputs a one-hot pick and an any flag. Reuse it for future channel arbiters.
- The top level contains the FSM, the grant and pointer registers, mode_q, and the muxes.

Test Plan:
- Single requester: req[0]=1 with an Ascon-AEAD128 encrypt vector (key 000102..0F, nonce, empty AD, PT 00..07). Expect gnt=01 one cycle later, r_bdo[0] matches the KAT, r_done[0] pulses once, then gnt=00 and one IDLE cycle.
- Simultaneous req=11 from reset: requester 0 is served first, then after the bubble requester 1 is served. r_bdi_ready[1]=0 throughout requester 0's transaction.
- Both requesters continuously requesting 3 operations each: grant order 0,1,0,1,0,1. Each r_done is routed only to its owner.
- req[0] deasserted mid-transaction: gnt stays 01 until c_done and the operation completes correctly.
- Mode latch: r_mode[1] changes from encrypt to hash during BUSY. c_mode stays at the grant-time value.
- Reset asserted mid-BUSY: gnt, busy and all r_* outputs are 0 asynchronously. After release, req=10 grants requester 1 and the full KAT passes.

Source files
------------

// File: rtl/ascon_core_arbiter_pkg.sv
// Shared definitions for the ascon_core arbiter slice.
//   arb_state_t   : arbiter FSM encoding (IDLE / BUSY)
//   NREQ_DEFAULT  : default number of requester channels
//   CCW_DEFAULT   : core data/key width in bits
package ascon_core_arbiter_pkg;

    localparam int NREQ_DEFAULT = 2;
    localparam int CCW_DEFAULT  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ascon_core_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector
//   ptr  : index with the highest priority this round (must be < NREQ)
//   pick : one-hot of the first set request at or after ptr, wrapping
//   any  : at least one request is set
module ascon_core_arbiter_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic            any
);

    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Walk NREQ positions starting at ptr; one spare bit in sum keeps
    // ptr + k from overflowing before the modulo wrap.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/ascon_core_arbiter.sv
// Transaction-level round-robin arbiter in front of a single ascon_core.
// A grant is taken in IDLE, held through the whole operation until c_done,
// and always followed by one IDLE cycle before the next grant.
//   clk, rst      : clock, asynchronous active-low reset (shared with core)
//   req / gnt     : per-requester request, registered one-hot grant
//   r_*           : requester-side copies of the core interface
//   c_*           : core-side interface (directions inverted w.r.t. core)
//   busy          : a grant is active
//   dbg_state     : current FSM state
// Handshakes: every valid/ready pair transfers on a cycle where both are 1;
// only the granted requester is ever connected, so a non-granted requester
// sees ready=0/valid=0 and its own valids simply stall.
module ascon_core_arbiter
    import ascon_core_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int CCW  = CCW_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req,
    output logic [NREQ-1:0]               gnt,
    input  logic [NREQ-1:0][CCW-1:0]      r_key,
    input  logic [NREQ-1:0]               r_key_valid,
    output logic [NREQ-1:0]               r_key_ready,
    input  logic [NREQ-1:0][CCW-1:0]      r_bdi,
    input  logic [NREQ-1:0][CCW/8-1:0]    r_bdi_valid,
    output logic [NREQ-1:0]               r_bdi_ready,
    input  logic [NREQ-1:0][3:0]          r_bdi_type,
    input  logic [NREQ-1:0]               r_bdi_eot,
    input  logic [NREQ-1:0]               r_bdi_eoi,
    input  logic [NREQ-1:0][3:0]          r_mode,
    output logic [NREQ-1:0][CCW-1:0]      r_bdo,
    output logic [NREQ-1:0]               r_bdo_valid,
    input  logic [NREQ-1:0]               r_bdo_ready,
    output logic [NREQ-1:0][3:0]          r_bdo_type,
    output logic [NREQ-1:0]               r_bdo_eot,
    input  logic [NREQ-1:0]               r_bdo_eoo,
    output logic [NREQ-1:0]               r_auth,
    output logic [NREQ-1:0]               r_auth_valid,
    output logic [NREQ-1:0]               r_done,
    output logic [CCW-1:0]                c_key,
    output logic                          c_key_valid,
    input  logic                          c_key_ready,
    output logic [CCW-1:0]                c_bdi,
    output logic [CCW/8-1:0]              c_bdi_valid,
    input  logic                          c_bdi_ready,
    output logic [3:0]                    c_bdi_type,
    output logic                          c_bdi_eot,
    output logic                          c_bdi_eoi,
    output logic [3:0]                    c_mode,
    input  logic [CCW-1:0]                c_bdo,
    input  logic                          c_bdo_valid,
    output logic                          c_bdo_ready,
    input  logic [3:0]                    c_bdo_type,
    input  logic                          c_bdo_eot,
    output logic                          c_bdo_eoo,
    input  logic                          c_auth,
    input  logic                          c_auth_valid,
    input  logic                          c_done,
    output logic                          busy,
    output arb_state_t                    dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state, state_next;
    logic [NREQ-1:0] gnt_q;
    logic [PW-1:0]   ptr_q, ptr_next;
    logic [3:0]      mode_q, pick_mode;
    logic [NREQ-1:0] pick;
    logic            any_req;
    logic [PW-1:0]   gidx;

    ascon_core_arbiter_rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any_req)
    );

    // Mode of the requester about to be granted; captured once at grant.
    always_comb begin
        pick_mode = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_mode = r_mode[i];
        end
    end

    // Index of the current grant holder, used by every mux below.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) gidx = PW'(i);
        end
    end

    assign ptr_next = (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);

    // State, grant, pointer and latched mode registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            gnt_q  <= '0;
            ptr_q  <= '0;
            mode_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                gnt_q  <= pick;
                mode_q <= pick_mode;
            end else if (state == BUSY && c_done) begin
                gnt_q <= '0;
                ptr_q <= ptr_next;
            end
        end
    end

    // Next state: c_done in IDLE is spurious and ignored; req changes in
    // BUSY are ignored because the core cannot be aborted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = BUSY;
            BUSY:    if (c_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output muxes: everything is zero unless a grant is active.
    always_comb begin
        c_key        = '0;
        c_key_valid  = 1'b0;
        c_bdi        = '0;
        c_bdi_valid  = '0;
        c_bdi_type   = '0;
        c_bdi_eot    = 1'b0;
        c_bdi_eoi    = 1'b0;
        c_mode       = '0;
        c_bdo_ready  = 1'b0;
        c_bdo_eoo    = 1'b0;
        r_key_ready  = '0;
        r_bdi_ready  = '0;
        r_bdo        = '0;
        r_bdo_valid  = '0;
        r_bdo_type   = '0;
        r_bdo_eot    = '0;
        r_auth       = '0;
        r_auth_valid = '0;
        r_done       = '0;
        if (state == BUSY) begin
            c_key              = r_key[gidx];
            c_key_valid        = r_key_valid[gidx];
            c_bdi              = r_bdi[gidx];
            c_bdi_valid        = r_bdi_valid[gidx];
            c_bdi_type         = r_bdi_type[gidx];
            c_bdi_eot          = r_bdi_eot[gidx];
            c_bdi_eoi          = r_bdi_eoi[gidx];
            c_mode             = mode_q;
            c_bdo_ready        = r_bdo_ready[gidx];
            c_bdo_eoo          = r_bdo_eoo[gidx];
            r_key_ready[gidx]  = c_key_ready;
            r_bdi_ready[gidx]  = c_bdi_ready;
            r_bdo[gidx]        = c_bdo;
            r_bdo_valid[gidx]  = c_bdo_valid;
            r_bdo_type[gidx]   = c_bdo_type;
            r_bdo_eot[gidx]    = c_bdo_eot;
            r_auth[gidx]       = c_auth;
            r_auth_valid[gidx] = c_auth_valid;
            r_done[gidx]       = c_done;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state == BUSY);
    assign dbg_state = state;

endmodule

// File: tb/tb_ascon_core_arbiter.sv
module tb_ascon_core_arbiter;
  import ascon_core_arbiter_pkg::*;

  localparam int NREQ = 2;
  localparam int CCW  = 32;

  logic                       clk;
  logic                       rst;
  logic [NREQ-1:0]            req;
  logic [NREQ-1:0]            gnt;
  logic [NREQ-1:0][CCW-1:0]   r_key;
  logic [NREQ-1:0]            r_key_valid;
  logic [NREQ-1:0]            r_key_ready;
  logic [NREQ-1:0][CCW-1:0]   r_bdi;
  logic [NREQ-1:0][CCW/8-1:0] r_bdi_valid;
  logic [NREQ-1:0]            r_bdi_ready;
  logic [NREQ-1:0][3:0]       r_bdi_type;
  logic [NREQ-1:0]            r_bdi_eot;
  logic [NREQ-1:0]            r_bdi_eoi;
  logic [NREQ-1:0][3:0]       r_mode;
  logic [NREQ-1:0][CCW-1:0]   r_bdo;
  logic [NREQ-1:0]            r_bdo_valid;
  logic [NREQ-1:0]            r_bdo_ready;
  logic [NREQ-1:0][3:0]       r_bdo_type;
  logic [NREQ-1:0]            r_bdo_eot;
  logic [NREQ-1:0]            r_bdo_eoo;
  logic [NREQ-1:0]            r_auth;
  logic [NREQ-1:0]            r_auth_valid;
  logic [NREQ-1:0]            r_done;
  logic [CCW-1:0]             c_key;
  logic                       c_key_valid;
  logic                       c_key_ready;
  logic [CCW-1:0]             c_bdi;
  logic [CCW/8-1:0]           c_bdi_valid;
  logic                       c_bdi_ready;
  logic [3:0]                 c_bdi_type;
  logic                       c_bdi_eot;
  logic                       c_bdi_eoi;
  logic [3:0]                 c_mode;
  logic [CCW-1:0]             c_bdo;
  logic                       c_bdo_valid;
  logic                       c_bdo_ready;
  logic [3:0]                 c_bdo_type;
  logic                       c_bdo_eot;
  logic                       c_bdo_eoo;
  logic                       c_auth;
  logic                       c_auth_valid;
  logic                       c_done;
  logic                       busy;
  arb_state_t                 dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  ascon_core_arbiter #(.NREQ(NREQ), .CCW(CCW)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .r_key(r_key), .r_key_valid(r_key_valid), .r_key_ready(r_key_ready),
    .r_bdi(r_bdi), .r_bdi_valid(r_bdi_valid), .r_bdi_ready(r_bdi_ready),
    .r_bdi_type(r_bdi_type), .r_bdi_eot(r_bdi_eot), .r_bdi_eoi(r_bdi_eoi),
    .r_mode(r_mode), .r_bdo(r_bdo), .r_bdo_valid(r_bdo_valid),
    .r_bdo_ready(r_bdo_ready), .r_bdo_type(r_bdo_type), .r_bdo_eot(r_bdo_eot),
    .r_bdo_eoo(r_bdo_eoo), .r_auth(r_auth), .r_auth_valid(r_auth_valid),
    .r_done(r_done),
    .c_key(c_key), .c_key_valid(c_key_valid), .c_key_ready(c_key_ready),
    .c_bdi(c_bdi), .c_bdi_valid(c_bdi_valid), .c_bdi_ready(c_bdi_ready),
    .c_bdi_type(c_bdi_type), .c_bdi_eot(c_bdi_eot), .c_bdi_eoi(c_bdi_eoi),
    .c_mode(c_mode), .c_bdo(c_bdo), .c_bdo_valid(c_bdo_valid),
    .c_bdo_ready(c_bdo_ready), .c_bdo_type(c_bdo_type), .c_bdo_eot(c_bdo_eot),
    .c_bdo_eoo(c_bdo_eoo), .c_auth(c_auth), .c_auth_valid(c_auth_valid),
    .c_done(c_done), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 2ns+ after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    req = '0; r_key = '0; r_key_valid = '0; r_bdi = '0; r_bdi_valid = '0;
    r_bdi_type = '0; r_bdi_eot = '0; r_bdi_eoi = '0; r_mode = '0;
    r_bdo_ready = '0; r_bdo_eoo = '0;
    c_key_ready = 1'b0; c_bdi_ready = 1'b0; c_bdo = '0; c_bdo_valid = 1'b0;
    c_bdo_type = '0; c_bdo_eot = 1'b0; c_auth = 1'b0; c_auth_valid = 1'b0;
    c_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (gnt != '0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    req = '1; r_key_valid = '1; c_key_ready = 1'b1; c_done = 1'b1;
    c_bdo_valid = 1'b1; c_bdo = 32'hdeadbeef; c_auth = 1'b1; c_auth_valid = 1'b1;
    r_bdo_ready = '1;
    #1;
    n_checks++; if (gnt !== 2'b00) begin n_errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    n_checks++; if (r_key_ready !== 2'b00 || r_done !== 2'b00 || r_auth_valid !== 2'b00 || r_bdo_valid !== 2'b00) begin
      n_errors++; $display("FAIL reset_r_outputs: got key_ready=%b done=%b auth_valid=%b bdo_valid=%b expected all 0",
                           r_key_ready, r_done, r_auth_valid, r_bdo_valid); end
    n_checks++; if (r_bdo !== '0) begin n_errors++; $display("FAIL reset_r_bdo: got %h expected 0", r_bdo); end
    n_checks++; if (c_key_valid !== 1'b0 || c_bdo_ready !== 1'b0 || c_mode !== 4'h0) begin
      n_errors++; $display("FAIL reset_c_outputs: got key_valid=%b bdo_ready=%b mode=%h expected 0",
                           c_key_valid, c_bdo_ready, c_mode); end
    clear_inputs();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    req = 2'b01; r_mode[0] = 4'h1;
    #1;
    n_checks++; if (gnt !== 2'b00) begin n_errors++; $display("FAIL single_latency: got %b expected 00", gnt); end
    step();
    n_checks++; if (gnt !== 2'b01 || busy !== 1'b1) begin n_errors++; $display("FAIL single_gnt: got gnt=%b busy=%b expected 01/1", gnt, busy); end
    n_checks++; if (c_mode !== 4'h1) begin n_errors++; $display("FAIL single_mode: got %h expected 1", c_mode); end
    // key word
    r_key[0] = 32'h00010203; r_key_valid[0] = 1'b1;
    r_key[1] = 32'hffffffff; r_key_valid[1] = 1'b1;
    c_key_ready = 1'b1;
    #1;
    n_checks++; if (c_key !== 32'h00010203 || c_key_valid !== 1'b1) begin
      n_errors++; $display("FAIL single_key: got %h/%b expected 00010203/1", c_key, c_key_valid); end
    n_checks++; if (r_key_ready !== 2'b01) begin n_errors++; $display("FAIL single_key_ready: got %b expected 01", r_key_ready); end
    // plaintext word
    r_bdi[0] = 32'h00010203; r_bdi_valid[0] = 4'hf; r_bdi_type[0] = 4'h4;
    r_bdi_eot[0] = 1'b1; r_bdi_eoi[0] = 1'b1; c_bdi_ready = 1'b1;
    #1;
    n_checks++; if (c_bdi !== 32'h00010203 || c_bdi_valid !== 4'hf || c_bdi_type !== 4'h4 || c_bdi_eot !== 1'b1 || c_bdi_eoi !== 1'b1) begin
      n_errors++; $display("FAIL single_bdi: got %h/%h/%h/%b/%b expected 00010203/f/4/1/1",
                           c_bdi, c_bdi_valid, c_bdi_type, c_bdi_eot, c_bdi_eoi); end
    n_checks++; if (r_bdi_ready !== 2'b01) begin n_errors++; $display("FAIL single_bdi_ready: got %b expected 01", r_bdi_ready); end
    // ciphertext word back to the requester
    c_bdo = 32'hbc18c3f4; c_bdo_valid = 1'b1; c_bdo_type = 4'h5; c_bdo_eot = 1'b1;
    r_bdo_ready[0] = 1'b1; r_bdo_eoo[0] = 1'b1;
    c_auth = 1'b1; c_auth_valid = 1'b1;
    #1;
    n_checks++; if (r_bdo[0] !== 32'hbc18c3f4 || r_bdo[1] !== 32'h0) begin
      n_errors++; $display("FAIL single_bdo: got %h/%h expected bc18c3f4/0", r_bdo[0], r_bdo[1]); end
    n_checks++; if (r_bdo_valid !== 2'b01 || r_bdo_type[0] !== 4'h5 || r_bdo_eot !== 2'b01) begin
      n_errors++; $display("FAIL single_bdo_ctl: got %b/%h/%b expected 01/5/01", r_bdo_valid, r_bdo_type[0], r_bdo_eot); end
    n_checks++; if (c_bdo_ready !== 1'b1 || c_bdo_eoo !== 1'b1) begin
      n_errors++; $display("FAIL single_bdo_ready: got %b/%b expected 1/1", c_bdo_ready, c_bdo_eoo); end
    n_checks++; if (r_auth !== 2'b01 || r_auth_valid !== 2'b01) begin
      n_errors++; $display("FAIL single_auth: got %b/%b expected 01/01", r_auth, r_auth_valid); end
    c_done = 1'b1; req = 2'b00;
    #1;
    n_checks++; if (r_done !== 2'b01) begin n_errors++; $display("FAIL single_done: got %b expected 01", r_done); end
    step();
    clear_inputs();
    #1;
    n_checks++; if (gnt !== 2'b00 || busy !== 1'b0) begin n_errors++; $display("FAIL single_release: got gnt=%b busy=%b expected 00/0", gnt, busy); end
  endtask

  task automatic test_both();
    do_reset();
    req = 2'b11; r_bdi_valid[0] = 4'hf; r_bdi_valid[1] = 4'hf; c_bdi_ready = 1'b1;
    step();
    n_checks++; if (gnt !== 2'b01) begin n_errors++; $display("FAIL both_first: got %b expected 01", gnt); end
    n_checks++; if (r_bdi_ready !== 2'b01) begin n_errors++; $display("FAIL both_bdi_ready: got %b expected 01", r_bdi_ready); end
    step();
    n_checks++; if (r_bdi_ready[1] !== 1'b0) begin n_errors++; $display("FAIL both_bdi_ready1: got %b expected 0", r_bdi_ready[1]); end
    c_done = 1'b1;
    #1;
    n_checks++; if (r_done !== 2'b01) begin n_errors++; $display("FAIL both_done0: got %b expected 01", r_done); end
    step();
    c_done = 1'b0;
    #1;
    n_checks++; if (gnt !== 2'b00 || dbg_state !== IDLE) begin
      n_errors++; $display("FAIL both_bubble: got gnt=%b state=%0d expected 00/0", gnt, dbg_state); end
    step();
    n_checks++; if (gnt !== 2'b10) begin n_errors++; $display("FAIL both_second: got %b expected 10", gnt); end
    n_checks++; if (r_bdi_ready !== 2'b10) begin n_errors++; $display("FAIL both_bdi_ready_2nd: got %b expected 10", r_bdi_ready); end
    c_done = 1'b1; req = 2'b00;
    #1;
    n_checks++; if (r_done !== 2'b10) begin n_errors++; $display("FAIL both_done1: got %b expected 10", r_done); end
    step();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] exp_gnt;
    bit ok;
    do_reset();
    req = 2'b11; r_mode[0] = 4'h1; r_mode[1] = 4'h3;
    for (int k = 0; k < 6; k++) begin
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_gnt(ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL b2b_timeout[%0d]: got no grant expected %b", k, exp_gnt); end
      n_checks++; if (gnt !== exp_gnt) begin n_errors++; $display("FAIL b2b_order[%0d]: got %b expected %b", k, gnt, exp_gnt); end
      n_checks++; if (c_mode !== ((k % 2 == 0) ? 4'h1 : 4'h3)) begin
        n_errors++; $display("FAIL b2b_mode[%0d]: got %h expected %h", k, c_mode, (k % 2 == 0) ? 4'h1 : 4'h3); end
      step();
      c_done = 1'b1;
      #1;
      n_checks++; if (r_done !== exp_gnt) begin n_errors++; $display("FAIL b2b_done[%0d]: got %b expected %b", k, r_done, exp_gnt); end
      step();
      c_done = 1'b0;
      #1;
      n_checks++; if (gnt !== 2'b00) begin n_errors++; $display("FAIL b2b_bubble[%0d]: got %b expected 00", k, gnt); end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_req_drop();
    req = 2'b01;
    step();
    n_checks++; if (gnt !== 2'b01) begin n_errors++; $display("FAIL drop_gnt: got %b expected 01", gnt); end
    req = 2'b00;
    repeat (3) step();
    n_checks++; if (gnt !== 2'b01 || busy !== 1'b1) begin n_errors++; $display("FAIL drop_hold: got gnt=%b busy=%b expected 01/1", gnt, busy); end
    c_bdo = 32'h5a5a1234; c_bdo_valid = 1'b1; r_bdo_ready[0] = 1'b1;
    #1;
    n_checks++; if (r_bdo[0] !== 32'h5a5a1234 || r_bdo_valid !== 2'b01 || c_bdo_ready !== 1'b1) begin
      n_errors++; $display("FAIL drop_bdo: got %h/%b/%b expected 5a5a1234/01/1", r_bdo[0], r_bdo_valid, c_bdo_ready); end
    c_done = 1'b1;
    #1;
    n_checks++; if (r_done !== 2'b01) begin n_errors++; $display("FAIL drop_done: got %b expected 01", r_done); end
    step();
    clear_inputs();
    #1;
    n_checks++; if (gnt !== 2'b00) begin n_errors++; $display("FAIL drop_release: got %b expected 00", gnt); end
  endtask

  task automatic test_spurious_done();
    c_done = 1'b1;
    #1;
    n_checks++; if (r_done !== 2'b00) begin n_errors++; $display("FAIL spurious_done: got %b expected 00", r_done); end
    step();
    n_checks++; if (dbg_state !== IDLE || gnt !== 2'b00 || busy !== 1'b0) begin
      n_errors++; $display("FAIL spurious_state: got state=%0d gnt=%b busy=%b expected 0/00/0", dbg_state, gnt, busy); end
    c_done = 1'b0;
    step();
  endtask

  task automatic test_mode_latch();
    req = 2'b10; r_mode[1] = 4'h1;
    step();
    n_checks++; if (gnt !== 2'b10 || c_mode !== 4'h1) begin n_errors++; $display("FAIL mode_grant: got gnt=%b mode=%h expected 10/1", gnt, c_mode); end
    r_mode[1] = 4'h2;
    #1;
    n_checks++; if (c_mode !== 4'h1) begin n_errors++; $display("FAIL mode_hold_comb: got %h expected 1", c_mode); end
    step();
    n_checks++; if (c_mode !== 4'h1) begin n_errors++; $display("FAIL mode_hold_reg: got %h expected 1", c_mode); end
    c_done = 1'b1; req = 2'b00;
    step();
    clear_inputs();
    #1;
    n_checks++; if (c_mode !== 4'h0) begin n_errors++; $display("FAIL mode_idle: got %h expected 0", c_mode); end
  endtask

  task automatic test_reset_mid_busy();
    req = 2'b01;
    step();
    n_checks++; if (gnt !== 2'b01) begin n_errors++; $display("FAIL rstmid_gnt: got %b expected 01", gnt); end
    c_key_ready = 1'b1; r_key_valid = 2'b11; c_bdo_valid = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if (gnt !== 2'b00 || busy !== 1'b0 || dbg_state !== IDLE) begin
      n_errors++; $display("FAIL rstmid_async: got gnt=%b busy=%b state=%0d expected 00/0/0", gnt, busy, dbg_state); end
    n_checks++; if (r_key_ready !== 2'b00 || r_bdo_valid !== 2'b00 || c_key_valid !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_outputs: got %b/%b/%b expected 00/00/0", r_key_ready, r_bdo_valid, c_key_valid); end
    clear_inputs();
    step();
    rst = 1'b1;
    step();
    req = 2'b10; r_mode[1] = 4'h1;
    #1;
    n_checks++; if (gnt !== 2'b00) begin n_errors++; $display("FAIL rstmid_latency: got %b expected 00", gnt); end
    step();
    n_checks++; if (gnt !== 2'b10 || c_mode !== 4'h1) begin n_errors++; $display("FAIL rstmid_regrant: got gnt=%b mode=%h expected 10/1", gnt, c_mode); end
    r_key[1] = 32'h0c0d0e0f; r_key_valid[1] = 1'b1; c_key_ready = 1'b1;
    c_bdo = 32'h8b1f0e6a; c_bdo_valid = 1'b1; r_bdo_ready[1] = 1'b1;
    #1;
    n_checks++; if (c_key !== 32'h0c0d0e0f || r_key_ready !== 2'b10) begin
      n_errors++; $display("FAIL rstmid_key: got %h/%b expected 0c0d0e0f/10", c_key, r_key_ready); end
    n_checks++; if (r_bdo[1] !== 32'h8b1f0e6a || r_bdo[0] !== 32'h0 || r_bdo_valid !== 2'b10) begin
      n_errors++; $display("FAIL rstmid_bdo: got %h/%h/%b expected 8b1f0e6a/0/10", r_bdo[1], r_bdo[0], r_bdo_valid); end
    c_done = 1'b1; req = 2'b00;
    #1;
    n_checks++; if (r_done !== 2'b10) begin n_errors++; $display("FAIL rstmid_done: got %b expected 10", r_done); end
    step();
    clear_inputs();
    #1;
    n_checks++; if (gnt !== 2'b00) begin n_errors++; $display("FAIL rstmid_release: got %b expected 00", gnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    clear_inputs();
    step();
    test_reset();
    test_single();
    test_both();
    test_back_to_back();
    test_req_drop();
    test_spurious_done();
    test_mode_latch();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
